mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
Load/store controller sitting directly upstream of the 4 KB word-addressed data memory (word-write only, combinational read). Accepts byte/halfword/word load and store requests from the CPU datapath using a valid/ready handshake. Performs read-modify-write for sub-word stores and lane extraction with sign or zero extension for loads. Flags misaligned accesses instead of touching memory.

Parameters:
ADDR_W, 12, byte-address width; memory word index is [ADDR_W-1:2]
DATA_W, 32, data width; fixed, other values unsupported

Ports:
clk  in  1  single system clock, rising edge
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  request present
req_ready  out  1  controller idle and able to accept
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
req_unsigned  in  1  load zero-extends when 1; ignored for stores
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-justified
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  load result; 0 for stores and errors
resp_err  out  1  misaligned or reserved size; valid with resp_valid
dm_addr  out  ADDR_W-2  word index to memory
dm_din  out  32  write data to memory
dm_wen  out  1  memory write enable
dm_dout  in  32  memory read data, combinational from dm_addr

Behaviour:
- States: IDLE, RD, WR, RESP. Handshake fires on req_valid && req_ready. req_ready = (state == IDLE).
- On accept, register we, size, unsigned, addr, and wdata. dm_addr is always driven from the registered address, so it stays stable for the whole operation.
- Error check at accept: error if size = 11, half with addr[0] = 1, or word with addr[1:0] != 00. Error path is IDLE -> RESP with resp_err = 1, resp_rdata = 0, and no dm_wen.
- Load path is IDLE -> RD -> RESP.
  - In RD, capture dm_dout into rbuf.
  - In RESP, drive the extracted lane. Lanes are little-endian: byte n = bits [8n+7:8n], half selected by addr[1].
  - Sign-extend unless req_unsigned. A word load returns rbuf unchanged.
- Word store path is IDLE -> WR -> RESP. In WR: dm_wen = 1, dm_din = wdata.
- Sub-word store path is IDLE -> RD -> WR -> RESP.
  - In RD, capture dm_dout.
  - In WR, dm_din = captured word with the addressed byte/half lane replaced by wdata[7:0] or wdata[15:0]. All other lanes are unchanged.
- Latency from accept cycle to the resp_valid cycle: load 2, word store 2, sub-word store 3, error 1.
- dm_wen is asserted only in WR, for exactly one cycle per store. It is decoded from state, so rst drops it immediately.
- RESP lasts one cycle, then returns to IDLE; req_ready reasserts the cycle after RESP. There is no response backpressure; the consumer must take the pulse.
- Outputs are 0 outside RESP: resp_rdata = 0 and resp_err = 0.
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_err 0, resp_rdata 0, dm_wen 0, dm_din 0, dm_addr 0, and all internal registers 0.
- Reset mid-operation aborts the operation. No write occurs if rst is asserted before the WR edge, and no resp_valid is produced.
- req_valid while not ready is ignored; the requester must hold it.
- Addresses have no wrap concerns: the highest word (index 1023) is accessed like any other.

Decomposition:
- Shared package mem_pkg holds:
  - Size encodings SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10.
  - State encoding constants.
  - A lane-width constant.
- One natural sub-module, lane_unit (purely combinational), with two functions:
  - Store merge: old word, wdata, size, addr[1:0] -> merged word.
  - Load extract: word, size, unsigned, addr[1:0] -> result.
- FSM and registers stay in mem_access_ctrl.

Test Plan:
1. Assert rst, then release -> req_ready = 1, resp_valid = 0, dm_wen = 0, dm_addr = 0; an async rst pulse between edges clears the state immediately.
2. sw addr 0x100, data 0xDEADBEEF -> one dm_wen cycle with dm_addr = 0x040 and dm_din = 0xDEADBEEF; resp_valid 2 cycles after accept, resp_err = 0.
3. sb addr 0x101, data 0x123456AA over stored word 0xDEADBEEF -> dm_din = 0xDEADAAEF; resp_valid 3 cycles after accept; then sh addr 0x102, data 0x7777 -> dm_din = 0x7777AAEF.
4. Memory word 0xDEADAAEF at 0x100:
   - lb 0x103 -> 0xFFFFFFDE
   - lbu 0x103 -> 0x000000DE
   - lh 0x102 -> 0xFFFFDEAD
   - lhu 0x100 -> 0x0000AAEF
   - lw 0x100 -> 0xDEADAAEF
   - each response 2 cycles after accept.
5. lw 0x102, sh 0x101, and size = 11 -> resp_valid 1 cycle after accept with resp_err = 1, resp_rdata = 0, and dm_wen never asserted.
6. sb 0x100 with rst asserted during RD -> no dm_wen pulse and no resp_valid; a subsequent lw 0x100 returns the original word unchanged.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the load/store controller: access sizes, FSM states, lane width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_pkg;

  // Access size encodings carried on req_size.
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // Controller FSM states.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  // Width of one byte lane.
  localparam int LANE_W = 8;

  // Reserved size, or a halfword/word that does not sit on its natural boundary.
  function automatic logic access_err(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = off[0];
      SZ_W:    bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_lane_unit.sv
// Byte/halfword lane merge for stores and lane extract with sign/zero extension for loads.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports:
//   old_word     word currently held in memory (read-modify-write source / load word)
//   wdata        right-justified store data
//   size         access size (SZ_B / SZ_H / SZ_W)
//   byte_off     byte offset inside the word, addr[1:0]
//   is_unsigned  zero-extend load results when set
//   merged       old_word with the addressed lane replaced by wdata
//   rdata        extracted, extended load result
module lane_unit
  import mem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] old_word,
  input  logic [DATA_W-1:0] wdata,
  input  logic [1:0]        size,
  input  logic [1:0]        byte_off,
  input  logic              is_unsigned,
  output logic [DATA_W-1:0] merged,
  output logic [DATA_W-1:0] rdata
);

  logic [LANE_W-1:0]   byte_lane;
  logic [2*LANE_W-1:0] half_lane;

  // Lanes are little-endian: byte n lives at bits [8n+7:8n]; the half is picked by addr[1].
  always_comb begin
    merged = old_word;
    case (size)
      SZ_B:    merged[{byte_off, 3'b000} +: LANE_W]       = wdata[LANE_W-1:0];
      SZ_H:    merged[{byte_off[1], 4'b0000} +: 2*LANE_W] = wdata[2*LANE_W-1:0];
      default: merged = wdata;
    endcase
  end

  always_comb begin
    byte_lane = old_word[{byte_off, 3'b000} +: LANE_W];
    half_lane = old_word[{byte_off[1], 4'b0000} +: 2*LANE_W];
    case (size)
      SZ_B: rdata = {{(DATA_W-LANE_W){~is_unsigned & byte_lane[LANE_W-1]}}, byte_lane};
      SZ_H: rdata = {{(DATA_W-2*LANE_W){~is_unsigned & half_lane[2*LANE_W-1]}}, half_lane};
      default: rdata = old_word;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store controller in front of a word-only data memory: sub-word RMW stores, extended loads.
// Latency accept->resp_valid: load 2, word store 2, sub-word store 3, misaligned/reserved 1.
// Backpressure: req_ready only in IDLE; no response backpressure (resp_valid is a 1-cycle pulse).
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   req_valid/req_ready   request handshake
//   req_we, req_size, req_unsigned, req_addr, req_wdata   request fields
//   resp_valid, resp_rdata, resp_err                      completion pulse and result
//   dm_addr, dm_din, dm_wen, dm_dout                      data memory interface
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-3:0] dm_addr,
  output logic [DATA_W-1:0] dm_din,
  output logic              dm_wen,
  input  logic [DATA_W-1:0] dm_dout
);

  logic [1:0]        state;
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_uns;
  logic              r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] rbuf;

  logic              accept;
  logic              bad_req;
  logic [DATA_W-1:0] merged_word;
  logic [DATA_W-1:0] load_word;

  assign req_ready = (state == ST_IDLE);
  assign accept    = req_valid && req_ready;
  assign bad_req   = access_err(req_size, req_addr[1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      r_we    <= 1'b0;
      r_size  <= 2'b00;
      r_uns   <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      rbuf    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            r_we    <= req_we;
            r_size  <= req_size;
            r_uns   <= req_unsigned;
            r_err   <= bad_req;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            // Errors skip memory entirely; word stores need no read; everything else reads first.
            if (bad_req)
              state <= ST_RESP;
            else if (req_we && (req_size == SZ_W))
              state <= ST_WR;
            else
              state <= ST_RD;
          end
        end
        ST_RD: begin
          rbuf  <= dm_dout;
          state <= r_we ? ST_WR : ST_RESP;
        end
        ST_WR:   state <= ST_RESP;
        default: state <= ST_IDLE;
      endcase
    end
  end

  lane_unit #(.DATA_W(DATA_W)) u_lane (
    .old_word    (rbuf),
    .wdata       (r_wdata),
    .size        (r_size),
    .byte_off    (r_addr[1:0]),
    .is_unsigned (r_uns),
    .merged      (merged_word),
    .rdata       (load_word)
  );

  // Memory address comes straight from the registered request so it is stable for the whole op.
  assign dm_addr = r_addr[ADDR_W-1:2];
  // Write enable decoded from state so an async reset removes it immediately.
  assign dm_wen  = (state == ST_WR);
  assign dm_din  = dm_wen ? merged_word : '0;

  assign resp_valid = (state == ST_RESP);
  assign resp_err   = resp_valid && r_err;
  assign resp_rdata = (resp_valid && !r_err && !r_we) ? load_word : '0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [9:0]  dm_addr;
  logic [31:0] dm_din;
  logic        dm_wen;
  logic [31:0] dm_dout;

  int checks = 0;
  int errors = 0;

  mem_access_ctrl #(.ADDR_W(12), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .dm_addr      (dm_addr),
    .dm_din       (dm_din),
    .dm_wen       (dm_wen),
    .dm_dout      (dm_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory device: word write, combinational read.
  logic        mem_init;
  logic [31:0] mem [1024];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= i * 32'h9E3779B9;
    end else if (dm_wen) begin
      mem[dm_addr] <= dm_din;
    end
  end
  assign dm_dout = mem[dm_addr];

  // Reference memory image, updated only by the model.
  logic [31:0] ref_mem [1024];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Behavioural model from the access rules: byte offsets, masks, shifts.
  function automatic void model(input logic we, input logic [1:0] sz, input logic uns,
                                input logic [11:0] a, input logic [31:0] wd,
                                output logic [31:0] rd, output logic err, output int lat,
                                output int wens, output logic [31:0] din);
    int     off;
    int     nb;
    longint mask, oldw, v, nw, wdl;
    off  = int'(a) % 4;
    err  = (sz == 2'd3) || (sz == 2'd1 && (off % 2) != 0) || (sz == 2'd2 && off != 0);
    rd   = 32'h0;
    wens = 0;
    din  = 32'h0;
    lat  = 1;
    if (!err) begin
      nb   = 1 << sz;
      mask = (64'd1 << (8 * nb)) - 1;
      oldw = longint'(ref_mem[a >> 2]);
      wdl  = longint'(wd);
      if (!we) begin
        v = (oldw >> (8 * off)) & mask;
        if (!uns && (((v >> (8 * nb - 1)) & 1) != 0)) v = v | ~mask;
        rd  = v[31:0];
        lat = 2;
      end else begin
        nw = (oldw & ~(mask << (8 * off))) | ((wdl & mask) << (8 * off));
        din = nw[31:0];
        ref_mem[a >> 2] = din;
        wens = 1;
        lat  = (sz == 2'd2) ? 2 : 3;
      end
    end
  endfunction

  // Issue one request and watch it until resp_valid (bounded).
  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [11:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic err,
                        output int wens, output logic [31:0] din, output logic [9:0] wa,
                        output logic busy_ok);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    busy_ok = !req_ready;
    lat = -1; rd = 32'hx; err = 1'bx; wens = 0; din = 32'h0; wa = 10'h0;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) @(negedge clk);
      if (dm_wen) begin wens++; din = dm_din; wa = dm_addr; end
      if (resp_valid) begin lat = k; rd = resp_rdata; err = resp_err; break; end
    end
  endtask

  task automatic run_check(input string tag, input logic we, input logic [1:0] sz,
                           input logic uns, input logic [11:0] a, input logic [31:0] wd,
                           input logic [31:0] e_rd, input logic e_err, input int e_lat,
                           input int e_wens, input logic [31:0] e_din);
    int lat, wens;
    logic [31:0] rd, din;
    logic err, busy_ok;
    logic [9:0] wa;
    do_req(we, sz, uns, a, wd, lat, rd, err, wens, din, wa, busy_ok);
    chk({tag, "_busy"}, 32'(busy_ok), 32'd1);
    chk({tag, "_lat"}, 32'(lat), 32'(e_lat));
    chk({tag, "_rdata"}, rd, e_rd);
    chk({tag, "_err"}, 32'(err), 32'(e_err));
    chk({tag, "_wens"}, 32'(wens), 32'(e_wens));
    if (e_wens != 0) begin
      chk({tag, "_din"}, din, e_din);
      chk({tag, "_waddr"}, 32'(wa), 32'(a >> 2));
    end
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [11:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
    int          exp_wens;
    logic [31:0] exp_din;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] m_rd, m_din;
    logic        m_err, seen;
    int          m_lat, m_wens;
    logic [1:0]  sz;
    logic [11:0] a;
    logic        we, uns;
    logic [31:0] wd;
    logic [9:0]  widx;

    vecs.push_back(vec_t'{"sw100",  1'b1, 2'd2, 1'b0, 12'h100, 32'hDEADBEEF, 32'h0,        1'b0, 2, 1, 32'hDEADBEEF});
    vecs.push_back(vec_t'{"sb101",  1'b1, 2'd0, 1'b0, 12'h101, 32'h123456AA, 32'h0,        1'b0, 3, 1, 32'hDEADAAEF});
    vecs.push_back(vec_t'{"lb103",  1'b0, 2'd0, 1'b0, 12'h103, 32'h0,        32'hFFFFFFDE, 1'b0, 2, 0, 32'h0});
    vecs.push_back(vec_t'{"lbu103", 1'b0, 2'd0, 1'b1, 12'h103, 32'h0,        32'h000000DE, 1'b0, 2, 0, 32'h0});
    vecs.push_back(vec_t'{"lh102",  1'b0, 2'd1, 1'b0, 12'h102, 32'h0,        32'hFFFFDEAD, 1'b0, 2, 0, 32'h0});
    vecs.push_back(vec_t'{"lhu100", 1'b0, 2'd1, 1'b1, 12'h100, 32'h0,        32'h0000AAEF, 1'b0, 2, 0, 32'h0});
    vecs.push_back(vec_t'{"lw100",  1'b0, 2'd2, 1'b0, 12'h100, 32'h0,        32'hDEADAAEF, 1'b0, 2, 0, 32'h0});
    vecs.push_back(vec_t'{"sh102",  1'b1, 2'd1, 1'b0, 12'h102, 32'h00007777, 32'h0,        1'b0, 3, 1, 32'h7777AAEF});
    vecs.push_back(vec_t'{"lw100b", 1'b0, 2'd2, 1'b0, 12'h100, 32'h0,        32'h7777AAEF, 1'b0, 2, 0, 32'h0});
    vecs.push_back(vec_t'{"lw102e", 1'b0, 2'd2, 1'b0, 12'h102, 32'h0,        32'h0,        1'b1, 1, 0, 32'h0});
    vecs.push_back(vec_t'{"sh101e", 1'b1, 2'd1, 1'b0, 12'h101, 32'h0000BEEF, 32'h0,        1'b1, 1, 0, 32'h0});
    vecs.push_back(vec_t'{"sz3e",   1'b0, 2'd3, 1'b0, 12'h100, 32'h0,        32'h0,        1'b1, 1, 0, 32'h0});
    vecs.push_back(vec_t'{"swtop",  1'b1, 2'd2, 1'b0, 12'hFFC, 32'hCAFEF00D, 32'h0,        1'b0, 2, 1, 32'hCAFEF00D});
    vecs.push_back(vec_t'{"lbtop",  1'b0, 2'd0, 1'b0, 12'hFFF, 32'h0,        32'hFFFFFFCA, 1'b0, 2, 0, 32'h0});

    for (int i = 0; i < 1024; i++) ref_mem[i] = i * 32'h9E3779B9;

    // Reset state.
    rst = 1'b1; mem_init = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 12'h0; req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_wen", 32'(dm_wen), 32'd0);
    chk("rst_addr", 32'(dm_addr), 32'd0);
    chk("rst_din", dm_din, 32'h0);
    rst = 1'b0; mem_init = 1'b0;

    // Async reset between edges while a load is in RD.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 12'h100;
    @(negedge clk);
    req_valid = 1'b0;
    chk("arst_pre_ready", 32'(req_ready), 32'd0);
    chk("arst_pre_addr", 32'(dm_addr), 32'h040);
    #2 rst = 1'b1;
    #1;
    chk("arst_ready", 32'(req_ready), 32'd1);
    chk("arst_addr", 32'(dm_addr), 32'd0);
    #1 rst = 1'b0;
    seen = 1'b0;
    repeat (3) begin @(negedge clk); seen = seen | resp_valid | dm_wen; end
    chk("arst_no_resp", 32'(seen), 32'd0);

    // Directed table.
    foreach (vecs[i]) begin
      model(vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wd,
            m_rd, m_err, m_lat, m_wens, m_din);
      run_check(vecs[i].name, vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wd,
                vecs[i].exp_rd, vecs[i].exp_err, vecs[i].exp_lat, vecs[i].exp_wens, vecs[i].exp_din);
    end

    // sb aborted by reset during RD: no write, no response.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_addr = 12'h100; req_wdata = 32'h55;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    seen = 1'b0;
    #1 seen = seen | dm_wen | resp_valid;
    @(negedge clk);
    seen = seen | dm_wen | resp_valid;
    rst = 1'b0;
    repeat (4) begin @(negedge clk); seen = seen | dm_wen | resp_valid; end
    chk("abort_no_activity", 32'(seen), 32'd0);
    run_check("abort_lw", 1'b0, 2'd2, 1'b0, 12'h100, 32'h0, 32'h7777AAEF, 1'b0, 2, 0, 32'h0);

    // Randomized traffic against the model over a small set of hot words.
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 4))
        0: widx = 10'h000;
        1: widx = 10'h040;
        2: widx = 10'h3FF;
        3: widx = 10'h001;
        default: widx = 10'($urandom_range(0, 1023));
      endcase
      a   = {widx, 2'($urandom_range(0, 3))};
      sz  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      we  = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      wd  = $urandom;
      model(we, sz, uns, a, wd, m_rd, m_err, m_lat, m_wens, m_din);
      run_check("rnd", we, sz, uns, a, wd, m_rd, m_err, m_lat, m_wens, m_din);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
